// File: rtl/cnt_mod_div.sv
// cnt_mod_div: prescaled up/down modulo-MOD counter with cascade carry/borrow.
//
// A run-time prescaler divides clk by `num` (0 and 1 both mean divide-by-1).
// Each prescaler step moves `out` one position up or down modulo MOD.
// `tick` marks every step and `carry` marks every wrap, so the `carry` of one
// stage can drive the `en` of the next stage (running with num = 1).
//
// Optional feature: define CNT_MOD_DIV_LOAD_EN to add the `load`/`load_val`
// synchronous load path. Without the macro those ports are absent.
//
// Priority, highest first: rst > load > step.

module cnt_mod_div #(
    parameter int WIDTH = 6,
    parameter int MOD   = 60,
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] num,
    input  logic             en,
    input  logic             up,
`ifdef CNT_MOD_DIV_LOAD_EN
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             carry
);

    // The modulus must leave at least two states and fit in WIDTH bits.
    if (MOD < 2 || MOD > (1 << WIDTH)) begin : g_mod_range_err
        $error("cnt_mod_div: MOD=%0d is outside 2..2**WIDTH (WIDTH=%0d)", MOD, WIDTH);
    end

    // One extra bit keeps MOD itself representable when MOD == 2**WIDTH.
    localparam int             EW      = WIDTH + 1;
    localparam logic [EW-1:0]  MOD_EXT = EW'(MOD);
    localparam logic [EW-1:0]  MOD_TOP = EW'(MOD - 1);

    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] num_m1;
    logic             div_hit;
    logic             step;

    logic [EW-1:0]    out_ext;
    logic [EW-1:0]    out_inc;
    logic             wrap_up;
    logic             wrap_dn;
    logic [WIDTH-1:0] next_up;
    logic [WIDTH-1:0] next_dn;
    logic [WIDTH-1:0] next_out;
    logic             next_wrap;

`ifdef CNT_MOD_DIV_LOAD_EN
    logic [EW-1:0]    load_ext;
    logic [WIDTH-1:0] load_clamped;
`endif

    // Prescaler terminal compare. The >= lets a shrinking num step at once
    // instead of letting div run all the way around.
    always_comb begin
        num_m1  = num - DIV_W'(1);
        div_hit = (num <= DIV_W'(1)) || (div >= num_m1);
        step    = en && div_hit;
    end

    // Next count in both directions, computed in WIDTH+1 bits.
    always_comb begin
        out_ext   = {1'b0, out};
        out_inc   = out_ext + EW'(1);
        wrap_up   = (out_inc >= MOD_EXT);
        wrap_dn   = (out_ext == '0);
        next_up   = wrap_up ? '0 : out_inc[WIDTH-1:0];
        next_dn   = wrap_dn ? MOD_TOP[WIDTH-1:0] : (out - WIDTH'(1));
        next_out  = up ? next_up : next_dn;
        next_wrap = up ? wrap_up : wrap_dn;
    end

`ifdef CNT_MOD_DIV_LOAD_EN
    // Out-of-range load values saturate at the top count.
    always_comb begin
        load_ext     = {1'b0, load_val};
        load_clamped = (load_ext >= MOD_EXT) ? MOD_TOP[WIDTH-1:0] : load_val;
    end
`endif

    // Prescaler, counter and output pulses, all registered on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            div   <= '0;
            out   <= '0;
            tick  <= 1'b0;
            carry <= 1'b0;
        end
`ifdef CNT_MOD_DIV_LOAD_EN
        else if (load) begin
            div   <= '0;
            out   <= load_clamped;
            tick  <= 1'b0;
            carry <= 1'b0;
        end
`endif
        else if (step) begin
            div   <= '0;
            out   <= next_out;
            tick  <= 1'b1;
            carry <= next_wrap;
        end
        else begin
            if (en) begin
                div <= div + DIV_W'(1);
            end
            tick  <= 1'b0;
            carry <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cnt_mod_div.sv
// Directed testbench for cnt_mod_div (default WIDTH=6, MOD=60, DIV_W=32).
// A second instance, enabled by the first one's carry, forms a cascade.
// Load scenarios are exercised only when CNT_MOD_DIV_LOAD_EN is defined.

module tb_cnt_mod_div;

    logic        clk;
    logic        rst;
    logic [31:0] num;
    logic        en;
    logic        up;
    logic [5:0]  out;
    logic        tick;
    logic        carry;
    logic [5:0]  out2;
    logic        tick2;
    logic        carry2;
`ifdef CNT_MOD_DIV_LOAD_EN
    logic        load;
    logic [5:0]  load_val;
`endif

    int total = 0;
    int bad   = 0;

    cnt_mod_div #(.WIDTH(6), .MOD(60), .DIV_W(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .num      (num),
        .en       (en),
        .up       (up),
`ifdef CNT_MOD_DIV_LOAD_EN
        .load     (load),
        .load_val (load_val),
`endif
        .out      (out),
        .tick     (tick),
        .carry    (carry)
    );

    cnt_mod_div #(.WIDTH(6), .MOD(60), .DIV_W(32)) dut2 (
        .clk      (clk),
        .rst      (rst),
        .num      (32'd1),
        .en       (carry),
        .up       (1'b1),
`ifdef CNT_MOD_DIV_LOAD_EN
        .load     (1'b0),
        .load_val (6'd0),
`endif
        .out      (out2),
        .tick     (tick2),
        .carry    (carry2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle; leaves rst low and the caller sets up the run.
    task automatic pulse_reset();
        rst = 1'b1;
        clk1();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up = 1'b1; num = 32'd5;
        clk1();
        clk1();
        total++; if (out !== 6'd0)  begin bad++; $display("FAIL reset_out got=%0d exp=0", out); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b exp=0", tick); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b exp=0", carry); end
        total++; if (out2 !== 6'd0) begin bad++; $display("FAIL reset_out2 got=%0d exp=0", out2); end
        total++; if (tick2 !== 1'b0) begin bad++; $display("FAIL reset_tick2 got=%b exp=0", tick2); end
    endtask

    // num=5: ticks on edges 5, 10, 15 after reset release.
    task automatic test_first_step();
        pulse_reset();
        en = 1'b1; num = 32'd5; up = 1'b1;
        for (int e = 1; e <= 15; e++) begin
            logic [5:0] exp_out;
            logic       exp_tick;
            clk1();
            exp_out  = 6'(e / 5);
            exp_tick = (e % 5 == 0);
            total++; if (out !== exp_out) begin bad++; $display("FAIL first_step_out edge=%0d got=%0d exp=%0d", e, out, exp_out); end
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL first_step_tick edge=%0d got=%b exp=%b", e, tick, exp_tick); end
            total++; if (carry !== 1'b0) begin bad++; $display("FAIL first_step_carry edge=%0d got=%b exp=0", e, carry); end
        end
    endtask

    // num=1 counting up: 59 -> 0 with one carry pulse on edge 60.
    task automatic test_up_wrap();
        pulse_reset();
        en = 1'b1; num = 32'd1; up = 1'b1;
        for (int e = 1; e <= 62; e++) begin
            logic [5:0] exp_out;
            logic       exp_carry;
            clk1();
            exp_out   = 6'(e % 60);
            exp_carry = (e == 60);
            total++; if (out !== exp_out) begin bad++; $display("FAIL up_wrap_out edge=%0d got=%0d exp=%0d", e, out, exp_out); end
            total++; if (tick !== 1'b1) begin bad++; $display("FAIL up_wrap_tick edge=%0d got=%b exp=1", e, tick); end
            total++; if (carry !== exp_carry) begin bad++; $display("FAIL up_wrap_carry edge=%0d got=%b exp=%b", e, carry, exp_carry); end
        end
    endtask

    // 0 -> 59 (borrow), 59 -> 58, flip up, 58 -> 59, 59 -> 0 (carry).
    task automatic test_down_borrow();
        pulse_reset();
        en = 1'b1; num = 32'd1; up = 1'b0;
        clk1();
        total++; if (out !== 6'd59) begin bad++; $display("FAIL borrow_out got=%0d exp=59", out); end
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL borrow_carry got=%b exp=1", carry); end
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL borrow_tick got=%b exp=1", tick); end
        clk1();
        total++; if (out !== 6'd58) begin bad++; $display("FAIL down_out got=%0d exp=58", out); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL down_carry got=%b exp=0", carry); end
        up = 1'b1;
        clk1();
        total++; if (out !== 6'd59) begin bad++; $display("FAIL flip_out got=%0d exp=59", out); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL flip_carry got=%b exp=0", carry); end
        clk1();
        total++; if (out !== 6'd0) begin bad++; $display("FAIL flip_wrap_out got=%0d exp=0", out); end
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL flip_wrap_carry got=%b exp=1", carry); end
    endtask

    // num=10: six enabled edges (div=6), 20 disabled, then the step lands
    // on the 4th enabled edge. Then div=7 and num drops to 3: immediate step.
    task automatic test_enable_gating();
        pulse_reset();
        en = 1'b1; num = 32'd10; up = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            clk1();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL gate_pre_tick edge=%0d got=%b exp=0", e, tick); end
        end
        en = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            clk1();
            total++; if (out !== 6'd0) begin bad++; $display("FAIL gate_hold_out edge=%0d got=%0d exp=0", e, out); end
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL gate_hold_tick edge=%0d got=%b exp=0", e, tick); end
            total++; if (carry !== 1'b0) begin bad++; $display("FAIL gate_hold_carry edge=%0d got=%b exp=0", e, carry); end
        end
        en = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            logic exp_tick;
            clk1();
            exp_tick = (e == 4);
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL gate_resume_tick edge=%0d got=%b exp=%b", e, tick, exp_tick); end
        end
        total++; if (out !== 6'd1) begin bad++; $display("FAIL gate_resume_out got=%0d exp=1", out); end
        for (int e = 1; e <= 7; e++) begin
            clk1();
            total++; if (tick !== 1'b0) begin bad++; $display("FAIL div7_pre_tick edge=%0d got=%b exp=0", e, tick); end
        end
        num = 32'd3;
        clk1();
        total++; if (tick !== 1'b1) begin bad++; $display("FAIL num_drop_tick got=%b exp=1", tick); end
        total++; if (out !== 6'd2) begin bad++; $display("FAIL num_drop_out got=%0d exp=2", out); end
        for (int e = 1; e <= 3; e++) begin
            logic exp_tick;
            clk1();
            exp_tick = (e == 3);
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL num3_tick edge=%0d got=%b exp=%b", e, tick, exp_tick); end
        end
        total++; if (out !== 6'd3) begin bad++; $display("FAIL num3_out got=%0d exp=3", out); end
    endtask

`ifdef CNT_MOD_DIV_LOAD_EN
    task automatic test_load();
        pulse_reset();
        en = 1'b0; num = 32'd1; up = 1'b1;
        load = 1'b1; load_val = 6'd42;
        clk1();
        total++; if (out !== 6'd42) begin bad++; $display("FAIL load42_out got=%0d exp=42", out); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL load42_tick got=%b exp=0", tick); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL load42_carry got=%b exp=0", carry); end
        load_val = 6'd63;
        clk1();
        total++; if (out !== 6'd59) begin bad++; $display("FAIL load_clamp_out got=%0d exp=59", out); end
        load = 1'b0; en = 1'b1;
        clk1();
        total++; if (out !== 6'd0) begin bad++; $display("FAIL after_load_out got=%0d exp=0", out); end
        total++; if (carry !== 1'b1) begin bad++; $display("FAIL after_load_carry got=%b exp=1", carry); end
        load = 1'b1; load_val = 6'd10;
        clk1();
        total++; if (out !== 6'd10) begin bad++; $display("FAIL load_vs_step_out got=%0d exp=10", out); end
        total++; if (tick !== 1'b0) begin bad++; $display("FAIL load_vs_step_tick got=%b exp=0", tick); end
        load = 1'b0;
        clk1();
        total++; if (out !== 6'd11) begin bad++; $display("FAIL post_load_step_out got=%0d exp=11", out); end
        num = 32'd3;
        clk1();
        load = 1'b1; load_val = 6'd20;
        clk1();
        load = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            logic exp_tick;
            clk1();
            exp_tick = (e == 3);
            total++; if (tick !== exp_tick) begin bad++; $display("FAIL load_div_clear_tick edge=%0d got=%b exp=%b", e, tick, exp_tick); end
        end
        total++; if (out !== 6'd21) begin bad++; $display("FAIL load_div_clear_out got=%0d exp=21", out); end
        rst = 1'b1; load = 1'b1; load_val = 6'd42;
        clk1();
        total++; if (out !== 6'd0) begin bad++; $display("FAIL rst_over_load_out got=%0d exp=0", out); end
        rst = 1'b0; load = 1'b0;
    endtask
`endif

    // Stage 1 at num=1 wraps on edges 60 and 120; stage 2 follows one edge later.
    task automatic test_cascade();
        pulse_reset();
        en = 1'b1; num = 32'd1; up = 1'b1;
        for (int e = 1; e <= 125; e++) begin
            logic [5:0] exp_out1;
            logic [5:0] exp_out2;
            logic       exp_tick2;
            clk1();
            exp_out1  = 6'(e % 60);
            exp_out2  = 6'((e >= 61 ? 1 : 0) + (e >= 121 ? 1 : 0));
            exp_tick2 = (e == 61) || (e == 121);
            total++; if (out !== exp_out1) begin bad++; $display("FAIL cascade_out1 edge=%0d got=%0d exp=%0d", e, out, exp_out1); end
            total++; if (out2 !== exp_out2) begin bad++; $display("FAIL cascade_out2 edge=%0d got=%0d exp=%0d", e, out2, exp_out2); end
            total++; if (tick2 !== exp_tick2) begin bad++; $display("FAIL cascade_tick2 edge=%0d got=%b exp=%b", e, tick2, exp_tick2); end
            total++; if (carry2 !== 1'b0) begin bad++; $display("FAIL cascade_carry2 edge=%0d got=%b exp=0", e, carry2); end
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up = 1'b1; num = 32'd0;
`ifdef CNT_MOD_DIV_LOAD_EN
        load = 1'b0; load_val = 6'd0;
`endif
        clk1();
        test_reset();
        test_first_step();
        test_up_wrap();
        test_down_borrow();
        test_enable_gating();
`ifdef CNT_MOD_DIV_LOAD_EN
        test_load();
`endif
        test_cascade();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
